comparador_sequencia_jogadas: RTL and testbench

//  Sequential play checker for the memory game datapath. Each player move is compared against the

---
 rtl/comparador_sequencia_jogadas_if.sv | 49 ++++
 rtl/comparador_sequencia_jogadas.sv | 172 +++++++++++++++++
 tb/tb_comparador_sequencia_jogadas.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comparador_sequencia_jogadas_if.sv
// Bundle of the play-checker signals shared between the game controller
// (master) and the comparator (slave). Sequence memory read data also
// travels here, since the comparator drives its address.
interface comparador_sequencia_jogadas_if #(
    parameter int WIDTH = 4,
    parameter int AW    = 4
) ();

    logic             iniciar;
    logic [AW-1:0]    limite;
    logic [WIDTH-1:0] jogada;
    logic             jogada_valida;
    logic [WIDTH-1:0] esperado;
    logic [AW-1:0]    endereco;
    logic             igual;
    logic             acertou;
    logic             errou;
    logic             timeout;
    logic             ocupado;

    modport master (
        output iniciar,
        output limite,
        output jogada,
        output jogada_valida,
        output esperado,
        input  endereco,
        input  igual,
        input  acertou,
        input  errou,
        input  timeout,
        input  ocupado
    );

    modport slave (
        input  iniciar,
        input  limite,
        input  jogada,
        input  jogada_valida,
        input  esperado,
        output endereco,
        output igual,
        output acertou,
        output errou,
        output timeout,
        output ocupado
    );

endinterface

// File: rtl/comparador_sequencia_jogadas.sv
// Sequential play checker for the memory game. Each player move is latched,
// compared against the expected move at the current sequence address, and the
// address advances on every hit until the round limit is reached. A wrong move
// or an expired per-move timer ends the round with an error.
module comparador_sequencia_jogadas #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 0
) (
    input  logic                           clock,
    input  logic                           reset,
    comparador_sequencia_jogadas_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    // Timer only needs to count up to TIMEOUT-1; keep at least one bit so
    // the design still elaborates when the timeout is disabled.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        OCIOSO,
        ESPERA,
        COMPARA,
        ACERTO,
        ERRO
    } estado_t;

    estado_t          state;
    estado_t          next_state;

    logic [AW-1:0]    endereco_q;
    logic [AW-1:0]    endereco_d;
    logic [WIDTH-1:0] jogada_reg;
    logic [WIDTH-1:0] jogada_reg_d;
    logic [TW-1:0]    tmr;
    logic [TW-1:0]    tmr_d;
    logic             igual_q;
    logic             igual_d;
    logic             acertou_q;
    logic             acertou_d;
    logic             errou_q;
    logic             errou_d;
    logic             timeout_q;
    logic             timeout_d;
    logic             ocupado_q;
    logic             ocupado_d;

    logic             jogada_confere;
    logic             ultima_jogada;
    logic             tmr_expira;

    // Status terms shared by the next-state and output logic.
    assign jogada_confere = (jogada_reg == bus.esperado);
    assign ultima_jogada  = (endereco_q == bus.limite);
    assign tmr_expira     = (TIMEOUT > 0) && (tmr == TMR_LAST);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= OCIOSO;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; iniciar restarts the round from any state.
    always_comb begin
        next_state = state;
        if (bus.iniciar) begin
            next_state = ESPERA;
        end else begin
            case (state)
                ESPERA: begin
                    if (bus.jogada_valida) begin
                        next_state = COMPARA;
                    end else if (tmr_expira) begin
                        next_state = ERRO;
                    end
                end
                COMPARA: begin
                    if (!jogada_confere) begin
                        next_state = ERRO;
                    end else if (ultima_jogada) begin
                        next_state = ACERTO;
                    end else begin
                        next_state = ESPERA;
                    end
                end
                default: next_state = state;
            endcase
        end
    end

    // Next values of the registered outputs and datapath; igual is a pulse and
    // defaults low, everything else holds unless a transition updates it.
    always_comb begin
        endereco_d   = endereco_q;
        jogada_reg_d = jogada_reg;
        tmr_d        = tmr;
        igual_d      = 1'b0;
        acertou_d    = acertou_q;
        errou_d      = errou_q;
        timeout_d    = timeout_q;
        if (bus.iniciar) begin
            endereco_d = '0;
            tmr_d      = '0;
            acertou_d  = 1'b0;
            errou_d    = 1'b0;
            timeout_d  = 1'b0;
        end else begin
            case (state)
                ESPERA: begin
                    if (bus.jogada_valida) begin
                        jogada_reg_d = bus.jogada;
                    end else if (tmr_expira) begin
                        errou_d   = 1'b1;
                        timeout_d = 1'b1;
                    end else if (TIMEOUT > 0) begin
                        tmr_d = tmr + 1'b1;
                    end
                end
                COMPARA: begin
                    if (!jogada_confere) begin
                        errou_d = 1'b1;
                    end else if (ultima_jogada) begin
                        igual_d   = 1'b1;
                        acertou_d = 1'b1;
                    end else begin
                        igual_d    = 1'b1;
                        endereco_d = endereco_q + 1'b1;
                        tmr_d      = '0;
                    end
                end
                default: begin
                end
            endcase
        end
        ocupado_d = (next_state == ESPERA) || (next_state == COMPARA);
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            endereco_q <= '0;
            jogada_reg <= '0;
            tmr        <= '0;
            igual_q    <= 1'b0;
            acertou_q  <= 1'b0;
            errou_q    <= 1'b0;
            timeout_q  <= 1'b0;
            ocupado_q  <= 1'b0;
        end else begin
            endereco_q <= endereco_d;
            jogada_reg <= jogada_reg_d;
            tmr        <= tmr_d;
            igual_q    <= igual_d;
            acertou_q  <= acertou_d;
            errou_q    <= errou_d;
            timeout_q  <= timeout_d;
            ocupado_q  <= ocupado_d;
        end
    end

    assign bus.endereco = endereco_q;
    assign bus.igual    = igual_q;
    assign bus.acertou  = acertou_q;
    assign bus.errou    = errou_q;
    assign bus.timeout  = timeout_q;
    assign bus.ocupado  = ocupado_q;

endmodule

// File: tb/tb_comparador_sequencia_jogadas.sv
// Directed bench for the play checker: rounds won, lost, timed out, aborted,
// and strobes held across several cycles. Flags are compared as the vector
// {igual, acertou, errou, timeout, ocupado}.
module tb_comparador_sequencia_jogadas;

    localparam int WIDTH = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [4:0]       flags;

    comparador_sequencia_jogadas_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    comparador_sequencia_jogadas #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (10)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Asynchronous sequence memory model.
    assign bus.esperado = mem[bus.endereco];
    assign flags = {bus.igual, bus.acertou, bus.errou, bus.timeout, bus.ocupado};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cycle();
        @(negedge clock);
    endtask

    task automatic start_round();
        bus.iniciar = 1'b1;
        cycle();
        bus.iniciar = 1'b0;
    endtask

    task automatic strobe(input logic [WIDTH-1:0] j);
        bus.jogada        = j;
        bus.jogada_valida = 1'b1;
        cycle();
        bus.jogada_valida = 1'b0;
    endtask

    task automatic load_mem(input logic [WIDTH-1:0] m0, input logic [WIDTH-1:0] m1,
                            input logic [WIDTH-1:0] m2, input logic [WIDTH-1:0] m3);
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        mem[0] = m0;
        mem[1] = m1;
        mem[2] = m2;
        mem[3] = m3;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.iniciar       = i[0];
            bus.jogada_valida = ~i[0];
            cycle();
        end
        checks++;
        if (flags !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected %b", flags, 5'b00000);
        end
        checks++;
        if (bus.endereco !== 4'd0) begin
            failures++;
            $display("[TB] FAIL reset_endereco: got %0d expected 0", bus.endereco);
        end
        bus.iniciar       = 1'b0;
        bus.jogada_valida = 1'b0;
        reset             = 1'b0;
        cycle();
        checks++;
        if (flags !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL reset_idle: got %b expected %b", flags, 5'b00000);
        end
    endtask

    task automatic test_round_ok();
        reset_dut();
        load_mem(4'd1, 4'd2, 4'd4, 4'd0);
        bus.limite = 4'd2;
        start_round();
        checks++;
        if (flags !== 5'b00001 || bus.endereco !== 4'd0) begin
            failures++;
            $display("[TB] FAIL ok_start: got %b/%0d expected 00001/0", flags, bus.endereco);
        end
        strobe(4'd1);
        checks++;
        if (flags !== 5'b00001) begin
            failures++;
            $display("[TB] FAIL ok_compara: got %b expected 00001", flags);
        end
        cycle();
        checks++;
        if (flags !== 5'b10001 || bus.endereco !== 4'd1) begin
            failures++;
            $display("[TB] FAIL ok_move1: got %b/%0d expected 10001/1", flags, bus.endereco);
        end
        strobe(4'd2);
        cycle();
        checks++;
        if (flags !== 5'b10001 || bus.endereco !== 4'd2) begin
            failures++;
            $display("[TB] FAIL ok_move2: got %b/%0d expected 10001/2", flags, bus.endereco);
        end
        strobe(4'd4);
        cycle();
        checks++;
        if (flags !== 5'b11000 || bus.endereco !== 4'd2) begin
            failures++;
            $display("[TB] FAIL ok_move3: got %b/%0d expected 11000/2", flags, bus.endereco);
        end
        repeat (3) cycle();
        checks++;
        if (flags !== 5'b01000 || bus.endereco !== 4'd2) begin
            failures++;
            $display("[TB] FAIL ok_held: got %b/%0d expected 01000/2", flags, bus.endereco);
        end
    endtask

    task automatic test_wrong_move();
        reset_dut();
        load_mem(4'd1, 4'd2, 4'd4, 4'd8);
        bus.limite = 4'd3;
        start_round();
        strobe(4'd1);
        cycle();
        checks++;
        if (flags !== 5'b10001 || bus.endereco !== 4'd1) begin
            failures++;
            $display("[TB] FAIL wrong_move1: got %b/%0d expected 10001/1", flags, bus.endereco);
        end
        strobe(4'd8);
        cycle();
        checks++;
        if (flags !== 5'b00100 || bus.endereco !== 4'd1) begin
            failures++;
            $display("[TB] FAIL wrong_errou: got %b/%0d expected 00100/1", flags, bus.endereco);
        end
        strobe(4'd2);
        strobe(4'd1);
        cycle();
        checks++;
        if (flags !== 5'b00100 || bus.endereco !== 4'd1) begin
            failures++;
            $display("[TB] FAIL wrong_ignored: got %b/%0d expected 00100/1", flags, bus.endereco);
        end
    endtask

    task automatic test_timeout();
        reset_dut();
        load_mem(4'd1, 4'd2, 4'd0, 4'd0);
        bus.limite = 4'd1;
        start_round();
        repeat (9) cycle();
        checks++;
        if (flags !== 5'b00001) begin
            failures++;
            $display("[TB] FAIL tmo_before: got %b expected 00001", flags);
        end
        cycle();
        checks++;
        if (flags !== 5'b00110 || bus.endereco !== 4'd0) begin
            failures++;
            $display("[TB] FAIL tmo_expired: got %b/%0d expected 00110/0", flags, bus.endereco);
        end
        start_round();
        checks++;
        if (flags !== 5'b00001) begin
            failures++;
            $display("[TB] FAIL tmo_restart: got %b expected 00001", flags);
        end
        repeat (9) cycle();
        strobe(4'd1);
        checks++;
        if (flags !== 5'b00001) begin
            failures++;
            $display("[TB] FAIL tmo_last_strobe: got %b expected 00001", flags);
        end
        cycle();
        checks++;
        if (flags !== 5'b10001 || bus.endereco !== 4'd1) begin
            failures++;
            $display("[TB] FAIL tmo_hit: got %b/%0d expected 10001/1", flags, bus.endereco);
        end
        repeat (9) cycle();
        checks++;
        if (flags !== 5'b00001) begin
            failures++;
            $display("[TB] FAIL tmo_rearmed: got %b expected 00001", flags);
        end
        cycle();
        checks++;
        if (flags !== 5'b00110 || bus.endereco !== 4'd1) begin
            failures++;
            $display("[TB] FAIL tmo_second: got %b/%0d expected 00110/1", flags, bus.endereco);
        end
    endtask

    task automatic test_abort();
        reset_dut();
        load_mem(4'd1, 4'd2, 4'd4, 4'd8);
        bus.limite = 4'd3;
        start_round();
        strobe(4'd1);
        cycle();
        strobe(4'd2);
        cycle();
        checks++;
        if (flags !== 5'b10001 || bus.endereco !== 4'd2) begin
            failures++;
            $display("[TB] FAIL abort_setup: got %b/%0d expected 10001/2", flags, bus.endereco);
        end
        start_round();
        checks++;
        if (flags !== 5'b00001 || bus.endereco !== 4'd0) begin
            failures++;
            $display("[TB] FAIL abort_espera: got %b/%0d expected 00001/0", flags, bus.endereco);
        end
        strobe(4'd1);
        start_round();
        checks++;
        if (flags !== 5'b00001 || bus.endereco !== 4'd0) begin
            failures++;
            $display("[TB] FAIL abort_compara: got %b/%0d expected 00001/0", flags, bus.endereco);
        end
        strobe(4'd1);
        reset_dut();
        checks++;
        if (flags !== 5'b00000 || bus.endereco !== 4'd0) begin
            failures++;
            $display("[TB] FAIL reset_compara: got %b/%0d expected 00000/0", flags, bus.endereco);
        end
        cycle();
        checks++;
        if (flags !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL reset_ocioso: got %b expected 00000", flags);
        end
    endtask

    task automatic test_held_strobe();
        int  pulses;
        int  doubles;
        logic prev;
        reset_dut();
        load_mem(4'd2, 4'd2, 4'd0, 4'd0);
        bus.limite = 4'd1;
        start_round();
        pulses            = 0;
        doubles           = 0;
        prev              = 1'b0;
        bus.jogada        = 4'd2;
        bus.jogada_valida = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (i == 4) bus.jogada_valida = 1'b0;
            if (bus.igual) pulses++;
            if (bus.igual && prev) doubles++;
            prev = bus.igual;
        end
        checks++;
        if (pulses !== 2) begin
            failures++;
            $display("[TB] FAIL held_pulses: got %0d expected 2", pulses);
        end
        checks++;
        if (doubles !== 0) begin
            failures++;
            $display("[TB] FAIL held_consecutive: got %0d expected 0", doubles);
        end
        checks++;
        if (flags !== 5'b01000 || bus.endereco !== 4'd1) begin
            failures++;
            $display("[TB] FAIL held_final: got %b/%0d expected 01000/1", flags, bus.endereco);
        end
    endtask

    task automatic test_back_to_back();
        start_round();
        checks++;
        if (flags !== 5'b00001 || bus.endereco !== 4'd0) begin
            failures++;
            $display("[TB] FAIL b2b_restart: got %b/%0d expected 00001/0", flags, bus.endereco);
        end
        strobe(4'd2);
        cycle();
        checks++;
        if (flags !== 5'b10001 || bus.endereco !== 4'd1) begin
            failures++;
            $display("[TB] FAIL b2b_move: got %b/%0d expected 10001/1", flags, bus.endereco);
        end
        bus.limite = 4'd0;
        start_round();
        strobe(4'd2);
        cycle();
        checks++;
        if (flags !== 5'b11000 || bus.endereco !== 4'd0) begin
            failures++;
            $display("[TB] FAIL b2b_single_move: got %b/%0d expected 11000/0", flags, bus.endereco);
        end
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        reset             = 1'b1;
        bus.iniciar       = 1'b0;
        bus.limite        = '0;
        bus.jogada        = '0;
        bus.jogada_valida = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_round_ok();
        test_wrong_move();
        test_timeout();
        test_abort();
        test_held_strobe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
